// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared constants and helpers for the register-file writeback
//            arbiter (default widths, zero register, requester slicing).
// Revision : 1.0  initial release
// ============================================================================
package rf_pkg;

    // Default register address and data widths
    localparam int c_ADDR_WIDTH = 5;
    localparam int c_DATA_WIDTH = 32;

    // Architectural zero register: never written, never pending
    localparam int c_ZERO_REG = 0;

    // LSB position of requester idx inside a packed {reqN-1 .. req0} bus
    // whose per-requester field is width bits wide.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter. Grants the first asserted
//            request found searching upward from ptr, modulo NREQ.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic          w_found;
    logic [PW-1:0] w_cand;

    // Rotating priority search starting at ptr; first hit wins
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = PW'((int'(ptr) + k) % NREQ);
            if (!w_found && req[w_cand]) begin
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
                w_found     = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Shares the register-file write port between NREQ writeback
//            requesters (round robin, 1-cycle registered write output) and
//            keeps a per-register pending scoreboard for RAW hazard checks.
// Revision : 1.0  initial release
// ============================================================================
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_rd,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       issue_valid,
    input  logic [ADDR_WIDTH-1:0]      issue_rd,
    input  logic [ADDR_WIDTH-1:0]      chk_rs1,
    input  logic [ADDR_WIDTH-1:0]      chk_rs2,
    output logic                       hazard_rs1,
    output logic                       hazard_rs2,
    output logic                       rf_wen,
    output logic [ADDR_WIDTH-1:0]      rf_rd,
    output logic [DATA_WIDTH-1:0]      rf_busW
);

    localparam int c_PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_NREG = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_X0 = ADDR_WIDTH'(c_ZERO_REG);

    logic [c_PW-1:0]       r_ptr;
    logic [c_PW-1:0]       w_ptr_nxt;
    logic [NREQ-1:0]       w_arb_gnt;
    logic [c_PW-1:0]       w_gnt_idx;
    logic                  w_xfer;
    logic [ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [c_NREG-1:0]     r_pending;
    logic [c_NREG-1:0]     w_pending_nxt;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (c_PW)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_arb_gnt),
        .idx (w_gnt_idx)
    );

    // Nothing is accepted while in reset, so the grant is masked off there
    assign req_ready = rst ? '0 : w_arb_gnt;
    assign w_xfer    = |req_ready;

    // Pointer moves just past the winner, wrapping at NREQ-1
    assign w_ptr_nxt = (w_gnt_idx == c_PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // One-hot mux of the winning requester's destination and data
    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_sel_rd   = req_rd[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
                w_sel_data = req_data[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    // Round-robin pointer: advances only on an accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Registered write port; a write to x0 is swallowed by holding wen low
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen  <= 1'b0;
            rf_rd   <= '0;
            rf_busW <= '0;
        end else if (w_xfer) begin
            rf_wen  <= (w_sel_rd != c_X0);
            rf_rd   <= w_sel_rd;
            rf_busW <= w_sel_data;
        end else begin
            rf_wen  <= 1'b0;
        end
    end

    // Scoreboard next state: clear the register being committed, then apply
    // the new reservation so a same-edge set beats the clear
    always_comb begin
        w_pending_nxt = r_pending;
        if (rf_wen) begin
            w_pending_nxt[rf_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != c_X0)) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
        w_pending_nxt[c_ZERO_REG] = 1'b0;
    end

    // Scoreboard state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign hazard_rs1 = r_pending[chk_rs1];
    assign hazard_rs2 = r_pending[chk_rs2];

endmodule : rf_wb_arbiter
`default_nettype wire
